// File: rtl/sr_run_pkg.sv
// rtl/sr_run_pkg.sv - shared command/state types for the schoolRISCV run-control sequencer
package sr_run_pkg;

  localparam int MAX_BP = 8;
  localparam int SLOT_W = $clog2(MAX_BP);

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    RUN       = 3'd1,
    HALT      = 3'd2,
    STEP      = 3'd3,
    RESET_CPU = 3'd4,
    SET_BP    = 3'd5,
    CLR_BP    = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_e;

endpackage

// File: rtl/sr_bp_match.sv
// rtl/sr_bp_match.sv - PC breakpoint bank with enable bits and lowest-index-wins comparator
module sr_bp_match
  import sr_run_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setEn,
  input  logic              clrEn,
  input  logic [SLOT_W-1:0] wrSlot,
  input  logic [31:0]       wrPc,
  input  logic [31:0]       pc,
  output logic              match,
  output logic [SLOT_W-1:0] slot
);

  logic [31:0]       bpPc [NUM_BP];
  logic [NUM_BP-1:0] bpEn;

  // Slots at or above NUM_BP never compare equal to wrSlot, so they are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpEn <= '0;
      for (int i = 0; i < NUM_BP; i++) bpPc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wrSlot == SLOT_W'(i)) begin
          if (setEn) begin
            bpEn[i] <= 1'b1;
            bpPc[i] <= wrPc;
          end else if (clrEn) begin
            bpEn[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    match = 1'b0;
    slot  = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bpEn[i] && bpPc[i] == pc) begin
        match = 1'b1;
        slot  = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/sr_run_ctrl.sv
// rtl/sr_run_ctrl.sv - run/halt/step/reset sequencer driving the core clock-enable and reset
module sr_run_ctrl
  import sr_run_pkg::*;
#(
  parameter int NUM_BP       = 4,
  parameter int RST_CYCLES   = 4,
  parameter bit HALT_ON_NOOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [2:0]  cmd_slot,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_noop,
  output logic        cpu_en,
  output logic        cpu_rst,
  output state_e      state,
  output logic        bp_hit,
  output logic [2:0]  bp_slot,
  output logic [31:0] retired
);

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

  state_e      stateQ, stateD;
  cmd_e        cmdOp;
  logic [15:0] rstCnt;
  logic [31:0] stepCnt;
  logic        skipQ;
  logic        cmdFire, haltCmd, active, bpRaw, bpM, bpStop;
  logic [2:0]  matchSlot;

  assign cmdOp     = cmd_e'(cmd_op);
  assign cmd_ready = (stateQ != S_RST);
  assign cmdFire   = cmd_valid && cmd_ready;
  assign haltCmd   = cmdFire && (cmdOp == HALT || cmdOp == RESET_CPU);
  assign active    = (stateQ == S_RUN) || (stateQ == S_STEP);
  assign bpM       = bpRaw && !skipQ;
  assign cpu_en    = active && !bpM && !haltCmd;
  assign cpu_rst   = (stateQ == S_RST);
  assign state     = stateQ;

  sr_bp_match #(.NUM_BP(NUM_BP)) uBpMatch (
    .clk    (clk),
    .rst_n  (rst_n),
    .setEn  (cmdFire && cmdOp == SET_BP),
    .clrEn  (cmdFire && cmdOp == CLR_BP),
    .wrSlot ((cmdOp == CLR_BP) ? cmd_arg[2:0] : cmd_slot),
    .wrPc   (cmd_arg),
    .pc     (cpu_pc),
    .match  (bpRaw),
    .slot   (matchSlot)
  );

  // Stop sources are checked in priority order: reset cmd, halt cmd, breakpoint, step-done, noop.
  always_comb begin
    stateD = stateQ;
    bpStop = 1'b0;
    case (stateQ)
      S_RST: begin
        if (rstCnt == RST_LAST) stateD = S_HALT;
      end
      S_HALT: begin
        if (cmdFire) begin
          case (cmdOp)
            RUN:       stateD = S_RUN;
            STEP:      stateD = S_STEP;
            RESET_CPU: stateD = S_RST;
            default:   stateD = S_HALT;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        if (cmdFire && cmdOp == RESET_CPU) begin
          stateD = S_RST;
        end else if (cmdFire && cmdOp == HALT) begin
          stateD = S_HALT;
        end else if (bpM) begin
          stateD = S_HALT;
          bpStop = 1'b1;
        end else if (stateQ == S_STEP && cpu_en && stepCnt == 32'd1) begin
          stateD = S_HALT;
        end else if (HALT_ON_NOOP && cpu_en && cpu_noop) begin
          stateD = S_HALT;
        end
      end
      default: stateD = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= S_RST;
      rstCnt  <= '0;
      stepCnt <= '0;
      skipQ   <= 1'b0;
      bp_hit  <= 1'b0;
      bp_slot <= '0;
      retired <= '0;
    end else begin
      stateQ <= stateD;

      if (stateQ == S_RST && stateD == S_RST) rstCnt <= rstCnt + 16'd1;
      else                                    rstCnt <= '0;

      // Skipping the first compare lets a resume execute the instruction that stopped us.
      if (stateQ == S_HALT && (stateD == S_RUN || stateD == S_STEP)) skipQ <= 1'b1;
      else if (cpu_en)                                                skipQ <= 1'b0;

      if (stateQ == S_HALT && stateD == S_STEP)
        stepCnt <= (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
      else if (stateQ == S_STEP && cpu_en)
        stepCnt <= stepCnt - 32'd1;

      if (bpStop) begin
        bp_hit  <= 1'b1;
        bp_slot <= matchSlot;
      end else if (cmdFire && (cmdOp == RUN || cmdOp == STEP)) begin
        bp_hit <= 1'b0;
      end

      if (cmdFire && cmdOp == RESET_CPU) retired <= '0;
      else if (cpu_en)                   retired <= retired + 32'd1;
    end
  end

  a_en_no_rst:  assert property (@(posedge clk) disable iff (!rst_n) cpu_en |-> !cpu_rst);
  a_rdy_no_rst: assert property (@(posedge clk) disable iff (!rst_n) cmd_ready |-> stateQ != S_RST);
  a_en_active:  assert property (@(posedge clk) disable iff (!rst_n)
                                 (stateQ == S_HALT || stateQ == S_RST) |-> !cpu_en);

endmodule

// File: tb/tb_sr_run_ctrl.sv
// tb/tb_sr_run_ctrl.sv - directed bench for sr_run_ctrl with a PC-stepping core model
module tb_sr_run_ctrl;
  import sr_run_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_arg = '0;
  logic [2:0]  cmd_slot = '0;
  logic [31:0] cpu_pc = '0;
  logic        cpu_noop;
  logic        cpu_en;
  logic        cpu_rst;
  state_e      state;
  logic        bp_hit;
  logic [2:0]  bp_slot;
  logic [31:0] retired;

  logic [31:0] noopPc = 32'hFFFF_FFFF;
  logic        enAtCmd;
  int          total = 0;
  int          bad = 0;
  int          n;

  sr_run_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_slot  (cmd_slot),
    .cpu_pc    (cpu_pc),
    .cpu_noop  (cpu_noop),
    .cpu_en    (cpu_en),
    .cpu_rst   (cpu_rst),
    .state     (state),
    .bp_hit    (bp_hit),
    .bp_slot   (bp_slot),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Minimal core: PC advances by 4 on each retiring cycle, resets to 0.
  always @(posedge clk) begin
    if (cpu_rst)     cpu_pc <= '0;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
  end
  assign cpu_noop = (cpu_pc == noopPc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sendCmd(input cmd_e op, input logic [31:0] arg, input logic [2:0] slot);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_slot  = slot;
    #1;
    enAtCmd = cpu_en;
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic waitHalt(output int enCnt);
    int k;
    enCnt = 0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (state == S_HALT) break;
      if (cpu_en) enCnt++;
    end
    chk("halt_timeout", 32'(k < 300), 32'd1);
  endtask

  task automatic countRst(output int cnt);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cpu_rst) break;
      cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and release
    #2;
    chk("rst_state", 32'(state), 32'(S_RST));
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    countRst(n);
    chk("t1_rst_cycles", n, 32'd4);
    chk("t1_state", 32'(state), 32'(S_HALT));
    chk("t1_ready", 32'(cmd_ready), 32'd1);
    chk("t1_cpu_en", 32'(cpu_en), 32'd0);
    chk("t1_retired", retired, 32'd0);

    // 2: STEP 3, then STEP 0 (treated as 1)
    sendCmd(STEP, 32'd3, 3'd0);
    waitHalt(n);
    chk("t2_en_cycles", n, 32'd3);
    chk("t2_pc", cpu_pc, 32'h0C);
    chk("t2_retired", retired, 32'd3);
    sendCmd(STEP, 32'd0, 3'd0);
    waitHalt(n);
    chk("t2_step0_en", n, 32'd1);
    chk("t2_step0_retired", retired, 32'd4);

    // 3: reset core, breakpoints (slot 1 and 3 on 0x10, slot 0 set then cleared), RUN
    sendCmd(RESET_CPU, 32'd0, 3'd0);
    chk("t3_rst_retired", retired, 32'd0);
    countRst(n);
    chk("t3_rst_cycles", n, 32'd4);
    chk("t3_pc0", cpu_pc, 32'd0);
    sendCmd(SET_BP, 32'h10, 3'd3);
    sendCmd(SET_BP, 32'h10, 3'd1);
    sendCmd(SET_BP, 32'h04, 3'd0);
    sendCmd(CLR_BP, 32'd0, 3'd0);
    chk("t3_still_halt", 32'(state), 32'(S_HALT));
    sendCmd(RUN, 32'd0, 3'd0);
    waitHalt(n);
    chk("t3_en_cycles", n, 32'd4);
    chk("t3_pc", cpu_pc, 32'h10);
    chk("t3_bp_hit", 32'(bp_hit), 32'd1);
    chk("t3_bp_slot", 32'(bp_slot), 32'd1);
    chk("t3_retired", retired, 32'd4);

    // 3/4: resume past the breakpoint, then HALT
    sendCmd(RUN, 32'd0, 3'd0);
    chk("t3_bp_clr", 32'(bp_hit), 32'd0);
    chk("t3_resume_state", 32'(state), 32'(S_RUN));
    repeat (3) @(posedge clk);
    sendCmd(HALT, 32'd0, 3'd0);
    chk("t4_en_at_halt", 32'(enAtCmd), 32'd0);
    chk("t4_state", 32'(state), 32'(S_HALT));
    chk("t4_retired", retired, 32'd7);
    chk("t4_pc", cpu_pc, 32'h1C);
    repeat (3) @(negedge clk);
    chk("t4_retired_hold", retired, 32'd7);

    // 5: RESET_CPU while running; breakpoints survive
    sendCmd(RUN, 32'd0, 3'd0);
    repeat (2) @(posedge clk);
    sendCmd(RESET_CPU, 32'd0, 3'd0);
    chk("t5_en_at_rst", 32'(enAtCmd), 32'd0);
    chk("t5_state", 32'(state), 32'(S_RST));
    chk("t5_retired", retired, 32'd0);
    countRst(n);
    chk("t5_rst_cycles", n, 32'd4);
    sendCmd(RUN, 32'd0, 3'd0);
    waitHalt(n);
    chk("t5_bp_pc", cpu_pc, 32'h10);
    chk("t5_bp_slot", 32'(bp_slot), 32'd1);
    chk("t5_retired_bp", retired, 32'd4);

    // 6: async reset mid-STEP, then noop halt with breakpoints gone
    sendCmd(STEP, 32'd100, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'(S_RST));
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_cpu_en", 32'(cpu_en), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd0);
    chk("t6_retired", retired, 32'd0);
    chk("t6_bp_hit", 32'(bp_hit), 32'd0);
    chk("t6_bp_slot", 32'(bp_slot), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    countRst(n);
    chk("t6_rst_cycles", n, 32'd4);
    noopPc = 32'h14;
    sendCmd(SET_BP, 32'h08, 3'd5);
    sendCmd(RUN, 32'd0, 3'd0);
    waitHalt(n);
    chk("t6_noop_en", n, 32'd6);
    chk("t6_noop_pc", cpu_pc, 32'h18);
    chk("t6_noop_retired", retired, 32'd6);
    chk("t6_noop_bp_hit", 32'(bp_hit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
